// File: rtl/coa_group_accum.sv
// Group collector for the COA result stream: folds GROUP consecutive results into a
// sum/max pair and queues completed groups in a small FIFO behind a valid/ready port.
module coa_group_accum #(
    parameter int DW    = 10,
    parameter int GROUP = 4,
    parameter int SW    = 12,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              din,
    input  logic                       din_valid,
    output logic [SW-1:0]              sum_out,
    output logic [DW-1:0]              max_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);

    localparam int CW = $clog2(GROUP);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [SW-1:0] acc_q, acc_d;
    logic [DW-1:0] mx_q, mx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic [SW-1:0] sum_mem [DEPTH];
    logic [DW-1:0] max_mem [DEPTH];

    logic [SW-1:0] sum_full;
    logic [DW-1:0] max_full;
    logic          complete;
    logic          fifo_full;
    logic          pop;
    logic          push;

    assign sum_full  = acc_q + SW'(din);
    assign max_full  = (din > mx_q) ? din : mx_q;
    assign complete  = din_valid && (cnt_q == CW'(GROUP - 1));
    assign fifo_full = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the new group when the head leaves on the same edge.
    assign push      = complete && (!fifo_full || pop);

    always_comb begin
        acc_d      = acc_q;
        mx_d       = mx_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (complete) begin
            acc_d = '0;
            mx_d  = '0;
            cnt_d = '0;
            if (!push) begin
                overflow_d = 1'b1;
            end
        end else if (din_valid) begin
            acc_d = sum_full;
            mx_d  = max_full;
            cnt_d = cnt_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            mx_q       <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mx_q       <= mx_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the level counter gates everything that reads it.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            sum_mem[wr_ptr_q] <= sum_full;
            max_mem[wr_ptr_q] <= max_full;
        end
    end

    assign sum_out    = out_valid ? sum_mem[rd_ptr_q] : '0;
    assign max_out    = out_valid ? max_mem[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_coa_group_accum.sv
// Directed self-checking bench for coa_group_accum with hand-computed expectations.
module tb_coa_group_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  din;
    logic        din_valid;
    logic [11:0] sum_out;
    logic [9:0]  max_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coa_group_accum dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sum_out    (sum_out),
        .max_out    (max_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock with the given input; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic v, input logic [9:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic group4(input logic [9:0] d);
        for (int i = 0; i < 4; i++) cyc(1'b1, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        #1;

        // Reset with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        end
        rst = 1'b0;
        out_ready = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_sum", sum_out, 0);
        check("rst_max", max_out, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);

        // Basic group with consumer always ready
        out_ready = 1'b1;
        cyc(1'b1, 10);
        cyc(1'b1, 20);
        cyc(1'b1, 30);
        check("basic_not_yet", out_valid, 0);
        cyc(1'b1, 5);
        check("basic_valid", out_valid, 1);
        check("basic_sum", sum_out, 65);
        check("basic_max", max_out, 30);
        check("basic_level", fifo_level, 1);
        cyc(1'b0, 0);
        check("basic_popped", out_valid, 0);
        check("basic_level0", fifo_level, 0);

        // Gaps between samples
        out_ready = 1'b0;
        cyc(1'b1, 7);
        cyc(1'b0, 0);
        cyc(1'b1, 8);
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        cyc(1'b1, 9);
        check("gap_not_yet", out_valid, 0);
        cyc(1'b1, 1);
        check("gap_sum", sum_out, 25);
        check("gap_max", max_out, 9);
        out_ready = 1'b1;
        cyc(1'b0, 0);
        check("gap_popped", fifo_level, 0);

        // Maximum values, no wrap
        out_ready = 1'b0;
        group4(10'd1023);
        check("max_sum", sum_out, 4092);
        check("max_max", max_out, 1023);
        out_ready = 1'b1;
        cyc(1'b0, 0);
        check("max_popped", fifo_level, 0);

        // Fill the FIFO and drop the third group
        out_ready = 1'b0;
        group4(10'd1);
        group4(10'd2);
        check("fill_level", fifo_level, 2);
        check("fill_ovf0", overflow, 0);
        group4(10'd3);
        check("drop_level", fifo_level, 2);
        check("drop_ovf", overflow, 1);
        check("drop_head_sum", sum_out, 4);
        check("drop_head_max", max_out, 1);
        out_ready = 1'b1;
        cyc(1'b0, 0);
        check("drop_second_sum", sum_out, 8);
        check("drop_second_max", max_out, 2);
        check("drop_level1", fifo_level, 1);
        cyc(1'b0, 0);
        check("drop_empty", out_valid, 0);
        check("drop_empty_sum", sum_out, 0);
        check("drop_ovf_sticky", overflow, 1);

        // Push into a full FIFO on the same edge as a pop
        do_reset();
        check("rst2_ovf", overflow, 0);
        out_ready = 1'b0;
        group4(10'd6);
        group4(10'd7);
        check("pp_full", fifo_level, 2);
        cyc(1'b1, 5);
        cyc(1'b1, 5);
        cyc(1'b1, 5);
        out_ready = 1'b1;
        cyc(1'b1, 5);
        check("pp_level", fifo_level, 2);
        check("pp_ovf", overflow, 0);
        check("pp_head_sum", sum_out, 28);
        cyc(1'b0, 0);
        check("pp_new_sum", sum_out, 20);
        check("pp_new_max", max_out, 5);
        cyc(1'b0, 0);
        check("pp_empty", fifo_level, 0);

        // Reset in the middle of a group
        out_ready = 1'b0;
        cyc(1'b1, 100);
        cyc(1'b1, 200);
        do_reset();
        cyc(1'b1, 1);
        cyc(1'b1, 2);
        cyc(1'b1, 3);
        check("mid_not_yet", out_valid, 0);
        cyc(1'b1, 4);
        check("mid_level", fifo_level, 1);
        check("mid_sum", sum_out, 10);
        check("mid_max", max_out, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coa_group_accum.md
# coa_group_accum

Downstream collector for the COA arithmetic stage. It takes the 10-bit result stream (`D` / `valid_out`), folds every GROUP consecutive results into a group sum and group maximum, and presents completed groups through a small output FIFO with a valid/ready handshake. The producer cannot be stalled, so this block absorbs bursts and flags any group it must drop.

## Interface

Parameters:
- DW, 10, input data width; matches the upstream `D` width.
- GROUP, 4, number of results per group; must be at least 2.
- SW, 12, sum width; must be at least DW + ceil(log2(GROUP)).
- DEPTH, 2, output FIFO entries.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DW  result word from upstream (`D`).
- din_valid  in  1  `din` is valid this cycle (upstream `valid_out`). No backpressure exists.
- sum_out  out  SW  group sum at the FIFO head.
- max_out  out  DW  group maximum at the FIFO head.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts the head entry.
- fifo_level  out  clog2(DEPTH)+1  number of FIFO entries currently held.
- overflow  out  1  sticky flag: a completed group was dropped.

## Operation

- The accumulator holds three registers: `acc` (SW bits), `mx` (DW bits) and `cnt` (0..GROUP-1).
- On each `din_valid` cycle that is not the last sample of a group (`cnt < GROUP-1`):
  - `acc <= acc + din`
  - `mx <= max(mx, din)`, compared as unsigned values
  - `cnt <= cnt + 1`
- On a `din_valid` cycle with `cnt == GROUP-1`, the group completes:
  - The completed entry is {`acc + din`, `max(mx, din)`}.
  - `acc`, `mx` and `cnt` return to 0 in that same edge. They do not start with `din`.
- Push rules for a completed entry:
  - If the FIFO is not full, the entry is pushed.
  - If the FIFO is full and a pop happens in the same cycle (`out_valid & out_ready`), the entry is still pushed.
  - If the FIFO is full with no pop, the entry is discarded and `overflow` is set to 1. Accumulation continues normally with the next group.
- Idle cycles (`din_valid = 0`) leave `acc`, `mx` and `cnt` unchanged. Samples in a group do not need to be consecutive.
- The sum never wraps: with the default parameters the worst case is 4 × 1023 = 4092, which fits in 12 bits.
- FIFO behaviour:
  - Circular buffer of DEPTH entries, in order, with wrap-around read and write pointers.
  - A pop happens when `out_valid & out_ready`.
  - `sum_out` and `max_out` show the head entry. When the FIFO is empty they are driven to 0.
  - Simultaneous push and pop: `fifo_level` is unchanged and the popped entry is the old head.
  - A push into an empty FIFO is visible on the outputs in the next cycle. There is no fall-through in the same cycle.
- `overflow` is cleared only by `rst`.

## Timing

- Reset sets `acc`, `mx`, `cnt`, both FIFO pointers and `fifo_level` to 0. In the cycle after reset: `sum_out = 0`, `max_out = 0`, `out_valid = 0`, `overflow = 0`.
- Reset has priority over all other inputs. Asserting `rst` in the middle of a group discards the partial group and clears every queued entry.
- Latency: when the last sample of a group is presented at edge N, `out_valid` rises after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: with `out_ready` held at 1, the block sustains one group every GROUP cycles with no loss.
- The consumer may hold `out_ready` at 1 continuously, or toggle it freely. When `out_valid` is 0, `out_ready` is ignored.
- `overflow` asserts in the cycle after the dropping edge.
- `fifo_level` is registered and reflects all pushes and pops from the previous edge.

## Test plan

- **Reset:** drive random inputs with `rst = 1`, then release → `out_valid = 0`, `sum_out = 0`, `max_out = 0`, `fifo_level = 0`, `overflow = 0`.
- **Basic group:** with `out_ready = 1`, feed 10, 20, 30, 5 back-to-back → exactly one cycle later `out_valid = 1`, `sum_out = 65`, `max_out = 30`; the entry pops the next cycle and `fifo_level` returns to 0.
- **Gaps and maximum values:**
  - Feed 7, idle, 8, idle ×3, 9, 1 → `sum_out = 25`, `max_out = 9`.
  - Then feed 1023 ×4 → `sum_out = 4092`, `max_out = 1023`, with no wrap.
- **Full FIFO and drop:** with `out_ready = 0`, feed three groups {1,1,1,1}, {2,2,2,2}, {3,3,3,3} → `fifo_level = 2`, `overflow = 1`. Then raise `out_ready` → pops return sums 4, 8 in order; group 3 is never seen; `overflow` stays 1.
- **Push while full with pop:** with the FIFO full, complete a group {5,5,5,5} in the same cycle as a pop → push accepted, `fifo_level` stays 2, `overflow` stays 0, and the next two pops return the older entry followed by sum 20.
- **Reset mid-group:** feed 100, 200, assert `rst` for one cycle, then feed 1, 2, 3, 4 → a single entry with `sum_out = 10`, `max_out = 4`.
